// File: rtl/burst_cas.sv
// CAS sequencer: buffers up to two column requests from the ACT sequencer and
// issues each one once tRCD and the CAS-to-CAS spacing rules are satisfied.
module burst_cas #(
    parameter int RCD_DELAY = 11,
    parameter int CCD_DELAY = 4,
    parameter int WTR_DELAY = 14,
    parameter int RTW_DELAY = 8,
    parameter int COL_WIDTH = 10
) (
    input  logic                 clock_t,
    input  logic                 reset_n,
    input  logic                 act_rdy,
    input  logic                 act_hit,
    input  logic                 act_rw,
    input  logic [1:0]           bg_addr,
    input  logic [1:0]           ba_addr,
    input  logic [COL_WIDTH-1:0] col_addr,
    output logic                 cas_rdy,
    output logic                 cas_rw,
    output logic [COL_WIDTH+3:0] cas_reg,
    output logic                 cas_idle,
    output logic                 cas_ovf
);

    localparam int ENT_W = COL_WIDTH + 5;

    localparam logic [1:0] CAS_IDLE = 2'd0;
    localparam logic [1:0] CAS_WAIT = 2'd1;
    localparam logic [1:0] CAS_CMD  = 2'd2;

    function automatic logic [7:0] dec_sat(input logic [7:0] v);
        return (v == 8'd0) ? v : v - 8'd1;
    endfunction

    function automatic logic [4:0] inc_sat(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    function automatic logic [7:0] gap_for(input logic prev_rw, input logic next_rw);
        if (prev_rw == next_rw)
            return 8'(CCD_DELAY);
        else if (prev_rw)
            return 8'(WTR_DELAY);
        else
            return 8'(RTW_DELAY);
    endfunction

    // Slot 0 is always the head; entry layout is {rw, bg, ba, col}.
    logic [ENT_W-1:0] fifo_ent [2];
    logic [ENT_W-1:0] ent_nxt  [2];
    logic [7:0]       fifo_rdy [2];
    logic [7:0]       rdy_nxt  [2];
    logic [1:0]       fifo_cnt;
    logic [1:0]       cnt_nxt;
    logic [1:0]       wr_slot;
    logic [1:0]       state;
    logic [4:0]       since_cnt;
    logic             last_rw;
    logic             head_rw;
    logic             issue;
    logic             push;
    logic [7:0]       gap;

    assign head_rw  = fifo_ent[0][ENT_W-1];
    assign gap      = gap_for(last_rw, head_rw);
    assign issue    = (state == CAS_WAIT) && (fifo_cnt != 2'd0) &&
                      (fifo_rdy[0] == 8'd0) && ({3'b000, since_cnt} >= gap - 8'd1);
    assign push     = act_rdy && ((fifo_cnt != 2'd2) || issue);
    assign wr_slot  = fifo_cnt - {1'b0, issue};
    assign cnt_nxt  = fifo_cnt + {1'b0, push} - {1'b0, issue};
    assign cas_idle = (fifo_cnt == 2'd0) && (state == CAS_IDLE);

    always_comb begin
        ent_nxt[0] = fifo_ent[0];
        ent_nxt[1] = fifo_ent[1];
        rdy_nxt[0] = dec_sat(fifo_rdy[0]);
        rdy_nxt[1] = dec_sat(fifo_rdy[1]);
        if (issue) begin
            ent_nxt[0] = fifo_ent[1];
            rdy_nxt[0] = dec_sat(fifo_rdy[1]);
        end
        if (push) begin
            if (wr_slot == 2'd0) begin
                ent_nxt[0] = {act_rw, bg_addr, ba_addr, col_addr};
                rdy_nxt[0] = act_hit ? 8'd0 : 8'(RCD_DELAY);
            end else begin
                ent_nxt[1] = {act_rw, bg_addr, ba_addr, col_addr};
                rdy_nxt[1] = act_hit ? 8'd0 : 8'(RCD_DELAY);
            end
        end
    end

    // Payload and countdowns are only meaningful below fifo_cnt, so they need no reset.
    always_ff @(posedge clock_t) begin
        fifo_ent <= ent_nxt;
        fifo_rdy <= rdy_nxt;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            fifo_cnt  <= 2'd0;
            state     <= CAS_IDLE;
            cas_rdy   <= 1'b0;
            cas_rw    <= 1'b0;
            cas_reg   <= '0;
            cas_ovf   <= 1'b0;
            since_cnt <= 5'd31;
            last_rw   <= 1'b0;
        end else begin
            fifo_cnt  <= cnt_nxt;
            since_cnt <= issue ? 5'd0 : inc_sat(since_cnt);
            if (act_rdy && !push)
                cas_ovf <= 1'b1;
            case (state)
                CAS_IDLE: begin
                    if (fifo_cnt != 2'd0)
                        state <= CAS_WAIT;
                end
                CAS_WAIT: begin
                    if (issue) begin
                        state   <= CAS_CMD;
                        cas_rdy <= 1'b1;
                        cas_rw  <= head_rw;
                        cas_reg <= fifo_ent[0][ENT_W-2:0];
                        last_rw <= head_rw;
                    end
                end
                CAS_CMD: begin
                    cas_rdy <= 1'b0;
                    state   <= (fifo_cnt != 2'd0) ? CAS_WAIT : CAS_IDLE;
                end
                default: begin
                    cas_rdy <= 1'b0;
                    state   <= CAS_IDLE;
                end
            endcase
        end
    end

endmodule
